triple_port_request_buffer: RTL and testbench

- Per-port request FIFO placed directly upstream of the triple-ported memory.
- Accepts address/data/write-enable requests from three independent clients using a valid/ready handshake.
- Presents each FIFO head to the memory's port inputs and pops it only on a cycle when the memory is not asserting freeze_inputs.
- Clients therefore never lose requests during bank-conflict stalls, and requests within a port stay in order.

---
 rtl/triple_port_request_buffer.sv | 193 +++++++++++++++++++
 tb/tb_triple_port_request_buffer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/triple_port_request_buffer.sv
// Three independent request FIFOs in front of a triple-ported memory.
// Heads pop only on cycles where the memory is not freezing its inputs.

module tprb_fifo #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              freeze_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_data_i,
    input  logic              req_wen_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              mem_wen_o,
    output logic              mem_valid_o,
    output logic [CNT_W-1:0]  count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = ADDR_W + DATA_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;
    logic [ENT_W-1:0] head;

    // Ready looks only at the registered count, never at a same-cycle pop.
    assign req_ready_o = (count_q != FULL) & ~reset_i;
    assign push        = req_valid_i & req_ready_o;
    assign pop         = (count_q != '0) & ~freeze_i;

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer and count registers; reset wins over any push or pop.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {req_addr_i, req_data_i, req_wen_i};
        end
    end

    assign head        = mem_q[rd_ptr_q];
    assign mem_valid_o = (count_q != '0);
    assign count_o     = count_q;

    // Empty FIFO drives zeros instead of stale storage.
    always_comb begin
        mem_addr_o = '0;
        mem_data_o = '0;
        mem_wen_o  = 1'b0;
        if (mem_valid_o) begin
            {mem_addr_o, mem_data_o, mem_wen_o} = head;
        end
    end

endmodule

module triple_port_request_buffer #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              freeze_inputs,

    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [DATA_W-1:0] p1_req_data,
    input  logic              p1_req_wen,
    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    output logic [ADDR_W-1:0] p1_mem_addr,
    output logic [DATA_W-1:0] p1_mem_data,
    output logic              p1_mem_wen,
    output logic              p1_mem_valid,
    output logic [CNT_W-1:0]  p1_count,

    input  logic [ADDR_W-1:0] p2_req_addr,
    input  logic [DATA_W-1:0] p2_req_data,
    input  logic              p2_req_wen,
    input  logic              p2_req_valid,
    output logic              p2_req_ready,
    output logic [ADDR_W-1:0] p2_mem_addr,
    output logic [DATA_W-1:0] p2_mem_data,
    output logic              p2_mem_wen,
    output logic              p2_mem_valid,
    output logic [CNT_W-1:0]  p2_count,

    input  logic [ADDR_W-1:0] p3_req_addr,
    input  logic [DATA_W-1:0] p3_req_data,
    input  logic              p3_req_wen,
    input  logic              p3_req_valid,
    output logic              p3_req_ready,
    output logic [ADDR_W-1:0] p3_mem_addr,
    output logic [DATA_W-1:0] p3_mem_data,
    output logic              p3_mem_wen,
    output logic              p3_mem_valid,
    output logic [CNT_W-1:0]  p3_count
);

    tprb_fifo #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) u_p1 (
        .clk_i      (clk),
        .reset_i    (reset),
        .freeze_i   (freeze_inputs),
        .req_addr_i (p1_req_addr),
        .req_data_i (p1_req_data),
        .req_wen_i  (p1_req_wen),
        .req_valid_i(p1_req_valid),
        .req_ready_o(p1_req_ready),
        .mem_addr_o (p1_mem_addr),
        .mem_data_o (p1_mem_data),
        .mem_wen_o  (p1_mem_wen),
        .mem_valid_o(p1_mem_valid),
        .count_o    (p1_count)
    );

    tprb_fifo #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) u_p2 (
        .clk_i      (clk),
        .reset_i    (reset),
        .freeze_i   (freeze_inputs),
        .req_addr_i (p2_req_addr),
        .req_data_i (p2_req_data),
        .req_wen_i  (p2_req_wen),
        .req_valid_i(p2_req_valid),
        .req_ready_o(p2_req_ready),
        .mem_addr_o (p2_mem_addr),
        .mem_data_o (p2_mem_data),
        .mem_wen_o  (p2_mem_wen),
        .mem_valid_o(p2_mem_valid),
        .count_o    (p2_count)
    );

    tprb_fifo #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) u_p3 (
        .clk_i      (clk),
        .reset_i    (reset),
        .freeze_i   (freeze_inputs),
        .req_addr_i (p3_req_addr),
        .req_data_i (p3_req_data),
        .req_wen_i  (p3_req_wen),
        .req_valid_i(p3_req_valid),
        .req_ready_o(p3_req_ready),
        .mem_addr_o (p3_mem_addr),
        .mem_data_o (p3_mem_data),
        .mem_wen_o  (p3_mem_wen),
        .mem_valid_o(p3_mem_valid),
        .count_o    (p3_count)
    );

endmodule

// File: tb/tb_triple_port_request_buffer.sv
// Directed stimulus for the triple-port request buffer.
// Popped heads are checked against per-port expected queues.

module tb_triple_port_request_buffer;

    typedef struct packed {
        logic [11:0] addr;
        logic [15:0] data;
        logic        wen;
    } req_t;

    logic clk = 1'b0;
    logic reset;
    logic freeze_inputs;

    req_t r_req [3];
    logic r_vld [3];

    logic [11:0] p1_req_addr, p2_req_addr, p3_req_addr;
    logic [15:0] p1_req_data, p2_req_data, p3_req_data;
    logic        p1_req_wen, p2_req_wen, p3_req_wen;
    logic        p1_req_valid, p2_req_valid, p3_req_valid;
    logic        p1_req_ready, p2_req_ready, p3_req_ready;
    logic [11:0] p1_mem_addr, p2_mem_addr, p3_mem_addr;
    logic [15:0] p1_mem_data, p2_mem_data, p3_mem_data;
    logic        p1_mem_wen, p2_mem_wen, p3_mem_wen;
    logic        p1_mem_valid, p2_mem_valid, p3_mem_valid;
    logic [2:0]  p1_count, p2_count, p3_count;

    assign {p1_req_addr, p1_req_data, p1_req_wen} = r_req[0];
    assign {p2_req_addr, p2_req_data, p2_req_wen} = r_req[1];
    assign {p3_req_addr, p3_req_data, p3_req_wen} = r_req[2];
    assign p1_req_valid = r_vld[0];
    assign p2_req_valid = r_vld[1];
    assign p3_req_valid = r_vld[2];

    req_t       m_head [3];
    logic       m_vld  [3];
    logic       m_rdy  [3];
    logic [2:0] m_cnt  [3];

    assign m_head[0] = {p1_mem_addr, p1_mem_data, p1_mem_wen};
    assign m_head[1] = {p2_mem_addr, p2_mem_data, p2_mem_wen};
    assign m_head[2] = {p3_mem_addr, p3_mem_data, p3_mem_wen};
    assign m_vld[0] = p1_mem_valid;
    assign m_vld[1] = p2_mem_valid;
    assign m_vld[2] = p3_mem_valid;
    assign m_rdy[0] = p1_req_ready;
    assign m_rdy[1] = p2_req_ready;
    assign m_rdy[2] = p3_req_ready;
    assign m_cnt[0] = p1_count;
    assign m_cnt[1] = p2_count;
    assign m_cnt[2] = p3_count;

    triple_port_request_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .freeze_inputs(freeze_inputs),
        .p1_req_addr  (p1_req_addr),
        .p1_req_data  (p1_req_data),
        .p1_req_wen   (p1_req_wen),
        .p1_req_valid (p1_req_valid),
        .p1_req_ready (p1_req_ready),
        .p1_mem_addr  (p1_mem_addr),
        .p1_mem_data  (p1_mem_data),
        .p1_mem_wen   (p1_mem_wen),
        .p1_mem_valid (p1_mem_valid),
        .p1_count     (p1_count),
        .p2_req_addr  (p2_req_addr),
        .p2_req_data  (p2_req_data),
        .p2_req_wen   (p2_req_wen),
        .p2_req_valid (p2_req_valid),
        .p2_req_ready (p2_req_ready),
        .p2_mem_addr  (p2_mem_addr),
        .p2_mem_data  (p2_mem_data),
        .p2_mem_wen   (p2_mem_wen),
        .p2_mem_valid (p2_mem_valid),
        .p2_count     (p2_count),
        .p3_req_addr  (p3_req_addr),
        .p3_req_data  (p3_req_data),
        .p3_req_wen   (p3_req_wen),
        .p3_req_valid (p3_req_valid),
        .p3_req_ready (p3_req_ready),
        .p3_mem_addr  (p3_mem_addr),
        .p3_mem_data  (p3_mem_data),
        .p3_mem_wen   (p3_mem_wen),
        .p3_mem_valid (p3_mem_valid),
        .p3_count     (p3_count)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    req_t exp_q [3][$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_port(input int p, input logic vld,
                            input logic [2:0] cnt, input logic rdy);
        chk($sformatf("p%0d_mem_valid", p + 1), 32'(m_vld[p]), 32'(vld));
        chk($sformatf("p%0d_count", p + 1), 32'(m_cnt[p]), 32'(cnt));
        chk($sformatf("p%0d_req_ready", p + 1), 32'(m_rdy[p]), 32'(rdy));
    endtask

    function automatic req_t mk(input logic [11:0] a,
                                input logic [15:0] d, input logic w);
        mk = '{addr: a, data: d, wen: w};
    endfunction

    // Any head that the memory will consume at the next edge is checked here.
    always @(negedge clk) begin : monitor
        req_t e;
        if (!reset) begin
            for (int p = 0; p < 3; p++) begin
                if (m_vld[p] && !freeze_inputs) begin
                    n_cmp++;
                    if (exp_q[p].size() == 0) begin
                        n_bad++;
                        $display("FAIL mon_p%0d: got head %h, want none",
                                 p + 1, m_head[p]);
                    end else begin
                        e = exp_q[p].pop_front();
                        if (m_head[p] !== e) begin
                            n_bad++;
                            $display("FAIL mon_p%0d: got head %h, want %h",
                                     p + 1, m_head[p], e);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        req_t h;
        reset         = 1'b1;
        freeze_inputs = 1'b0;
        for (int p = 0; p < 3; p++) begin
            r_req[p] = '0;
            r_vld[p] = 1'b0;
        end

        // Reset state.
        tick();
        for (int p = 0; p < 3; p++) chk_port(p, 1'b0, 3'd0, 1'b0);
        tick();
        reset = 1'b0;
        #1;
        for (int p = 0; p < 3; p++) chk_port(p, 1'b0, 3'd0, 1'b1);
        chk("p1_mem_addr_rst", 32'(p1_mem_addr), 32'h0);

        // Basic flow.
        r_req[0] = mk(12'h010, 16'hABCD, 1'b1);
        r_vld[0] = 1'b1;
        exp_q[0].push_back(r_req[0]);
        tick();
        r_vld[0] = 1'b0;
        #1;
        chk_port(0, 1'b1, 3'd1, 1'b1);
        chk("basic_addr", 32'(p1_mem_addr), 32'h010);
        chk("basic_data", 32'(p1_mem_data), 32'hABCD);
        chk("basic_wen", 32'(p1_mem_wen), 32'h1);
        tick();
        chk_port(0, 1'b0, 3'd0, 1'b1);

        // Freeze hold on p2.
        freeze_inputs = 1'b1;
        r_req[1] = mk(12'h222, 16'h2222, 1'b0);
        r_vld[1] = 1'b1;
        exp_q[1].push_back(r_req[1]);
        tick();
        r_vld[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("frz_head", 32'(m_head[1]), 32'(mk(12'h222, 16'h2222, 1'b0)));
            chk("frz_count", 32'(p2_count), 32'd1);
            tick();
        end
        freeze_inputs = 1'b0;
        #1;
        chk("frz_count_pre_pop", 32'(p2_count), 32'd1);
        tick();
        chk_port(1, 1'b0, 3'd0, 1'b1);

        // Full p3 under freeze; fifth request waits for the first pop.
        freeze_inputs = 1'b1;
        for (int i = 0; i < 4; i++) begin
            r_req[2] = mk(12'h300 + 12'(i), 16'h3000 + 16'(i), i[0]);
            r_vld[2] = 1'b1;
            exp_q[2].push_back(r_req[2]);
            #1;
            chk("full_rdy_acc", 32'(p3_req_ready), 32'h1);
            tick();
        end
        r_req[2] = mk(12'h304, 16'h3004, 1'b0);
        #1;
        chk_port(2, 1'b1, 3'd4, 1'b0);
        tick();
        chk_port(2, 1'b1, 3'd4, 1'b0);
        chk("full_head0", 32'(p3_mem_addr), 32'h300);
        freeze_inputs = 1'b0;
        #1;
        chk("full_rdy_popcyc", 32'(p3_req_ready), 32'h0);
        tick();
        chk_port(2, 1'b1, 3'd3, 1'b1);
        exp_q[2].push_back(r_req[2]);
        tick();
        r_vld[2] = 1'b0;
        #1;
        chk_port(2, 1'b1, 3'd3, 1'b1);
        tick();
        chk("drain_c2", 32'(p3_count), 32'd2);
        tick();
        chk("drain_c1", 32'(p3_count), 32'd1);
        chk("drain_last", 32'(p3_mem_addr), 32'h304);
        tick();
        chk_port(2, 1'b0, 3'd0, 1'b1);

        // Wrap-around with simultaneous push and pop.
        for (int i = 0; i < 10; i++) begin
            r_req[0] = mk(12'(i), 16'h5A00 + 16'(i), i[1]);
            r_vld[0] = 1'b1;
            exp_q[0].push_back(r_req[0]);
            if (i > 0) begin
                #1;
                chk("wrap_count", 32'(p1_count), 32'd1);
                chk("wrap_addr", 32'(p1_mem_addr), 32'(i - 1));
            end
            tick();
        end
        r_vld[0] = 1'b0;
        #1;
        chk("wrap_tail", 32'(p1_mem_addr), 32'd9);
        chk("wrap_tail_cnt", 32'(p1_count), 32'd1);
        tick();
        chk("wrap_empty", 32'(p1_count), 32'd0);

        // Port independence.
        freeze_inputs = 1'b1;
        for (int i = 0; i < 3; i++) begin
            r_vld[1] = (i < 2);
            r_req[1] = mk(12'h600 + 12'(i), 16'h6600 + 16'(i), 1'b1);
            if (i < 2) exp_q[1].push_back(r_req[1]);
            r_vld[2] = 1'b1;
            r_req[2] = mk(12'h700 + 12'(i), 16'h7700 + 16'(i), 1'b0);
            exp_q[2].push_back(r_req[2]);
            tick();
        end
        r_vld[1] = 1'b0;
        r_vld[2] = 1'b0;
        freeze_inputs = 1'b0;
        #1;
        chk_port(0, 1'b0, 3'd0, 1'b1);
        chk("ind_p2_c", 32'(p2_count), 32'd2);
        chk("ind_p3_c", 32'(p3_count), 32'd3);
        tick();
        chk("ind_p2_c1", 32'(p2_count), 32'd1);
        chk("ind_p3_c2", 32'(p3_count), 32'd2);
        tick();
        chk("ind_p2_c0", 32'(p2_count), 32'd0);
        chk("ind_p3_c1", 32'(p3_count), 32'd1);
        chk("ind_p1_v", 32'(p1_mem_valid), 32'd0);
        tick();
        chk("ind_p3_c0", 32'(p3_count), 32'd0);

        // Reset mid-operation discards entries and the in-flight push.
        freeze_inputs = 1'b1;
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 3; p++) begin
                r_req[p] = mk(12'h800 + 12'(p * 16 + i), 16'h8800, 1'b1);
                r_vld[p] = 1'b1;
            end
            tick();
        end
        for (int p = 0; p < 3; p++) chk(
            $sformatf("pre_rst_c%0d", p + 1), 32'(m_cnt[p]), 32'd2);
        reset = 1'b1;
        for (int p = 0; p < 3; p++) r_req[p] = mk(12'hBAD, 16'hBAD0, 1'b1);
        #1;
        for (int p = 0; p < 3; p++) chk(
            $sformatf("rst_rdy%0d", p + 1), 32'(m_rdy[p]), 32'd0);
        tick();
        reset = 1'b0;
        for (int p = 0; p < 3; p++) r_vld[p] = 1'b0;
        #1;
        for (int p = 0; p < 3; p++) chk_port(p, 1'b0, 3'd0, 1'b1);
        chk("rst_p2_addr", 32'(p2_mem_addr), 32'h0);
        freeze_inputs = 1'b0;
        tick();
        for (int p = 0; p < 3; p++) chk(
            $sformatf("rst_lost_v%0d", p + 1), 32'(m_vld[p]), 32'd0);

        // Post-reset traffic still flows.
        h = mk(12'h0AA, 16'h00AA, 1'b0);
        r_req[0] = h;
        r_vld[0] = 1'b1;
        exp_q[0].push_back(h);
        tick();
        r_vld[0] = 1'b0;
        #1;
        chk("post_rst_head", 32'(m_head[0]), 32'(h));
        tick();
        tick();
        for (int p = 0; p < 3; p++) chk(
            $sformatf("q%0d_left", p + 1), 32'(exp_q[p].size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
